// File: rtl/cd_pkg.sv
// Shared types and constants for the CD-ROM sector loader.
// Holds the loader state enum, sector geometry and sync pattern bytes.
package cd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } state_t;

  localparam int unsigned CNT_W         = 12;
  localparam int unsigned SECTOR_BYTES  = 2352;
  localparam int unsigned DATA_OFS_2048 = 24;
  localparam int unsigned DATA_LEN_2048 = 2048;
  localparam int unsigned DATA_OFS_2340 = 12;
  localparam int unsigned DATA_LEN_2340 = 2340;
  localparam int unsigned SYNC_BYTES    = 12;

  localparam logic [7:0] SYNC_EDGE = 8'h00;
  localparam logic [7:0] SYNC_MID  = 8'hFF;

  function automatic logic [7:0] sync_byte(
    input logic [CNT_W-1:0] ofs
  );
    return (ofs == '0 || ofs == CNT_W'(SYNC_BYTES - 1))
      ? SYNC_EDGE : SYNC_MID;
  endfunction

endpackage

// File: rtl/cd_sector_window.sv
// Data-window decode for the sector loader.
// Maps a raw byte offset and mode onto in-window and last-byte flags.
module cd_sector_window
  import cd_pkg::*;
(
  input  logic [CNT_W-1:0] byte_cnt,
  input  logic             mode,
  output logic             in_win,
  output logic             last_byte
);

  logic [CNT_W-1:0] ofs;
  logic [CNT_W-1:0] lim;

  always_comb begin
    ofs = mode ? CNT_W'(DATA_OFS_2340)
               : CNT_W'(DATA_OFS_2048);
    lim = mode ? CNT_W'(DATA_OFS_2340 + DATA_LEN_2340)
               : CNT_W'(DATA_OFS_2048 + DATA_LEN_2048);
  end

  assign in_win    = (byte_cnt >= ofs) && (byte_cnt < lim);
  assign last_byte = byte_cnt == CNT_W'(SECTOR_BYTES - 1);

endmodule

// File: rtl/cd_sector_loader.sv
// Raw sector stream to CD data FIFO write-port loader.
// Optional sync-pattern checker enabled by CD_LOADER_SYNC_CHECK_EN.
module cd_sector_loader
  import cd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       whole_sector,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       fifo_full,
  input  logic       fifo_rd_active,
  output logic       fifo_we,
  output logic [7:0] fifo_data,
  output logic       fifo_clr,
  output logic       busy,
  output logic       sector_done,
  output logic       sync_err
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] byte_cnt;
  logic             mode;
  logic             in_win;
  logic             last_byte;
  logic             accept;
  logic             take_start;

  cd_sector_window u_win (
    .byte_cnt  (byte_cnt),
    .mode      (mode),
    .in_win    (in_win),
    .last_byte (last_byte)
  );

  always_comb begin
    state_nx    = state;
    byte_ready  = 1'b0;
    fifo_clr    = 1'b0;
    sector_done = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = CLEAR;
      CLEAR: begin
        fifo_clr = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        byte_ready = !in_win || (!fifo_full && !fifo_rd_active);
        if (byte_valid && byte_ready && last_byte)
          state_nx = DONE;
      end
      DONE: begin
        sector_done = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort wins over everything, FIFO contents stay untouched
    if (abort) begin
      state_nx    = IDLE;
      byte_ready  = 1'b0;
      fifo_clr    = 1'b0;
      sector_done = 1'b0;
    end
  end

  assign accept     = byte_valid && byte_ready;
  assign fifo_we    = accept && in_win;
  assign fifo_data  = byte_data;
  assign busy       = state != IDLE;
  assign take_start = (state == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      mode     <= 1'b0;
    end else begin
      state <= state_nx;
      if (take_start) mode <= whole_sector;
      if (state == CLEAR) byte_cnt <= '0;
      else if (accept) byte_cnt <= byte_cnt + 1'b1;
    end
  end

`ifdef CD_LOADER_SYNC_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if (take_start) begin
      sync_err <= 1'b0;
    end else if (accept &&
                 byte_cnt < CNT_W'(SYNC_BYTES) &&
                 byte_data != sync_byte(byte_cnt)) begin
      sync_err <= 1'b1;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_cd_sector_loader.sv
// Bench for cd_sector_loader: control vector table plus full sectors
// checked against a per-offset reference model of the data window.
module tb_cd_sector_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       whole_sector;
  logic       abort;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       fifo_full;
  logic       fifo_rd_active;
  logic       fifo_we;
  logic [7:0] fifo_data;
  logic       fifo_clr;
  logic       busy;
  logic       sector_done;
  logic       sync_err;

  cd_sector_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .whole_sector   (whole_sector),
    .abort          (abort),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .fifo_full      (fifo_full),
    .fifo_rd_active (fifo_rd_active),
    .fifo_we        (fifo_we),
    .fifo_data      (fifo_data),
    .fifo_clr       (fifo_clr),
    .busy           (busy),
    .sector_done    (sector_done),
    .sync_err       (sync_err)
  );

  always #5 clk = ~clk;

`ifdef CD_LOADER_SYNC_CHECK_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  bit sflag  = 1'b0;

  typedef struct packed {
    logic start, whole, abort, valid, full, rd;
    logic busy, clr, done, ready, we;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t vec(input logic [5:0] i, input logic [4:0] o);
    return {i, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)",
                 name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start          = 1'b0;
    whole_sector   = 1'b0;
    abort          = 1'b0;
    byte_valid     = 1'b0;
    byte_data      = 8'h00;
    fifo_full      = 1'b0;
    fifo_rd_active = 1'b0;
  endtask

  function automatic logic [7:0] sync_val(input int k);
    return (k == 0 || k == 11) ? 8'h00 : 8'hFF;
  endfunction

  // pat: 0 random data with good sync, 1 data = offset[7:0]
  // stim: 0 continuous, 1 rd every 3rd in-window cycle, 2 random
  task automatic run_sector(input bit mode, input int pat, input int stim,
                            input int stall_at, input int abort_at,
                            input bit corrupt5);
    logic [7:0] d[2352];
    int ofs, len, k, cyc, wcount, stall_left, inwin_n, exp_w;
    bit stalled, aborted, iw, v, f, r, ab, rdy, we;
    logic [7:0] first_w, last_w;
    ofs = mode ? 12 : 24;
    len = mode ? 2340 : 2048;
    k = 0; cyc = 0; wcount = 0; stall_left = 0; inwin_n = 0;
    stalled = 0; aborted = 0;
    first_w = 8'h00; last_w = 8'h00;
    for (int i = 0; i < 2352; i++) begin
      d[i] = pat == 1 ? 8'(i) : 8'($urandom);
      if (pat == 0 && i < 12) d[i] = sync_val(i);
    end
    if (corrupt5) d[5] = 8'hFE;
    quiet();
    start = 1'b1;
    whole_sector = mode;
    #1;
    chk("start_busy", busy, 0);
    chk("start_sync", sync_err, sflag);
    step();
    sflag = 0;
    start = 1'b0;
    whole_sector = ~mode;
    byte_valid = 1'b1;
    byte_data = d[0];
    #1;
    chk("clr_pulse", fifo_clr, 1);
    chk("clr_busy", busy, 1);
    chk("clr_ready", byte_ready, 0);
    chk("clr_we", fifo_we, 0);
    chk("clr_sync", sync_err, 0);
    step();
    while (k < 2352 && cyc < 20000) begin
      iw = k >= ofs && k < ofs + len;
      v = 1; f = 0; r = 0; ab = 0;
      if (stim == 1 && iw) begin
        inwin_n++;
        r = (inwin_n % 3) == 0;
      end
      if (stim == 2) begin
        v = $urandom_range(0, 3) != 0;
        f = $urandom_range(0, 3) == 0;
        r = $urandom_range(0, 4) == 0;
      end
      if (k == stall_at && !stalled && stall_left == 0) stall_left = 5;
      if (stall_left > 0) f = 1;
      if (k == abort_at) ab = 1;
      byte_valid = v;
      fifo_full = f;
      fifo_rd_active = r;
      abort = ab;
      byte_data = d[k];
      #1;
      rdy = !ab && (!iw || (!f && !r));
      we = v && rdy && iw;
      chk("ready", byte_ready, rdy);
      chk("we", fifo_we, we);
      chk("busy", busy, 1);
      chk("clr_idle", fifo_clr, 0);
      chk("done_early", sector_done, 0);
      chk("sync_err", sync_err, sflag);
      if (we) begin
        wcount++;
        if (wcount == 1) first_w = fifo_data;
        last_w = fifo_data;
        chk("data", fifo_data, d[k]);
      end
      step();
      cyc++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stalled = 1;
      end
      if (ab) begin
        aborted = 1;
        break;
      end
      if (v && rdy) begin
        if (SYNC_ON && k < 12 && d[k] != sync_val(k)) sflag = 1;
        k++;
      end
    end
    quiet();
    #1;
    chk("finished", (k == 2352) || aborted, 1);
    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_done", sector_done, 0);
      exp_w = abort_at < ofs ? 0 :
              (abort_at > ofs + len ? len : abort_at - ofs);
    end else begin
      chk("done_pulse", sector_done, 1);
      chk("done_busy", busy, 1);
      chk("done_ready", byte_ready, 0);
      step();
      chk("done_clear", sector_done, 0);
      chk("idle_busy", busy, 0);
      exp_w = len;
      chk("first_w", first_w, d[ofs]);
      chk("last_w", last_w, d[ofs + len - 1]);
    end
    chk("wr_count", wcount, exp_w);
  endtask

  initial begin
    tbl[0] = vec(6'b000100, 5'b00000);
    tbl[1] = vec(6'b100100, 5'b00000);
    tbl[2] = vec(6'b000100, 5'b11000);
    tbl[3] = vec(6'b000100, 5'b10010);
    tbl[4] = vec(6'b000110, 5'b10010);
    tbl[5] = vec(6'b100000, 5'b10010);
    tbl[6] = vec(6'b001100, 5'b10000);
    tbl[7] = vec(6'b000100, 5'b00000);
    tbl[8] = vec(6'b101000, 5'b00000);
    tbl[9] = vec(6'b000000, 5'b00000);

    quiet();
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_clr", fifo_clr, 0);
    chk("rst_done", sector_done, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", fifo_we, 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_sync", sync_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start          = tbl[i].start;
      whole_sector   = tbl[i].whole;
      abort          = tbl[i].abort;
      byte_valid     = tbl[i].valid;
      fifo_full      = tbl[i].full;
      fifo_rd_active = tbl[i].rd;
      byte_data      = 8'h5A;
      #1;
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_clr", i), fifo_clr, tbl[i].clr);
      chk($sformatf("vec%0d_done", i), sector_done, tbl[i].done);
      chk($sformatf("vec%0d_ready", i), byte_ready, tbl[i].ready);
      chk($sformatf("vec%0d_we", i), fifo_we, tbl[i].we);
      step();
    end
    quiet();
    step();

    run_sector(1'b0, 0, 0, -1, -1, 1'b0);
    run_sector(1'b1, 1, 0, -1, -1, 1'b0);
    run_sector(1'b0, 0, 0, 500, -1, 1'b0);
    run_sector(1'b0, 0, 1, -1, -1, 1'b0);
    run_sector(1'b0, 0, 0, -1, 100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("gap_busy", busy, 0);
      chk("gap_done", sector_done, 0);
      step();
    end
    run_sector(1'b0, 0, 0, -1, -1, 1'b0);
    run_sector(1'b0, 0, 0, -1, -1, 1'b1);
    run_sector(1'b1, 0, 2, 40, -1, 1'b0);
    run_sector(1'b0, 0, 2, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cd_sector_loader.md
Name: cd_sector_loader

Overview:
- Write-side companion to the CD-ROM data FIFO: consumes the raw 2352-byte sector stream from the disc/drive model and pushes the user-visible bytes into the data FIFO's 8-bit write port.
- Clears the FIFO at sector start and selects the data window by mode.
- Throttles the drive stream on FIFO full or on an active CPU read.
- Pulses sector_done when the sector has been fully consumed.

Parameters:
- SECTOR_BYTES, 2352, raw bytes per sector including sync and header.
- DATA_OFS_2048, 24, first delivered byte offset in 2048-byte mode.
- DATA_LEN_2048, 2048, bytes delivered in 2048-byte mode.
- DATA_OFS_2340, 12, first delivered byte offset in whole-sector mode.
- DATA_LEN_2340, 2340, bytes delivered in whole-sector mode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: a new sector is beginning
- whole_sector  in  1  mode (1 = 2340-byte window, 0 = 2048-byte window); sampled on start
- abort  in  1  cancel the current sector
- byte_valid  in  1  drive stream byte valid
- byte_data  in  8  drive stream byte
- byte_ready  out  1  loader accepts byte this cycle
- fifo_full  in  1  data FIFO full flag
- fifo_rd_active  in  1  CPU read strobe (8- or 16-bit) to the FIFO this cycle
- fifo_we  out  1  FIFO write enable
- fifo_data  out  8  FIFO write data
- fifo_clr  out  1  FIFO clear
- busy  out  1  sector in progress
- sector_done  out  1  one-cycle completion pulse
- sync_err  out  1  sync pattern mismatch flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; byte_cnt=0; all outputs 0.
- States and transitions:
  - IDLE: on start, latch whole_sector and go to CLEAR. Otherwise stay.
  - CLEAR: fifo_clr=1 for exactly one cycle, byte_cnt←0, then go to STREAM.
  - STREAM: accepts bytes; on the accept of the byte at offset SECTOR_BYTES-1, go to DONE.
  - DONE: sector_done=1 for one cycle, then go to IDLE.
- busy=1 in CLEAR, STREAM and DONE.
- Window: in_win = (byte_cnt ≥ ofs) && (byte_cnt < ofs+len), using the latched mode's ofs/len.
  - Bytes outside the window are accepted and discarded.
  - Sync bytes 0–11 and, in 2048 mode, bytes 12–23 and 2072–2351 are never written.
- byte_ready = STREAM && (!in_win || (!fifo_full && !fifo_rd_active)).
  - Rationale: the FIFO ignores a write in a cycle it is read, so the loader must never write during fifo_rd_active.
- fifo_we = byte_valid && byte_ready && in_win, combinational, zero latency; fifo_data = byte_data.
  - fifo_we is never asserted when fifo_full=1 or fifo_rd_active=1.
- byte_cnt: 12-bit; increments on each accept (byte_valid && byte_ready); no wrap within a sector.
- start while busy: ignored.
- abort: highest priority over start and stream activity.
  - Next state IDLE; no sector_done.
  - fifo_we and byte_ready are forced 0 in the abort cycle.
  - FIFO contents are left as-is.
- rst mid-sector: same effect as abort, plus sync_err cleared.
- Expected FIFO fill at sector end is 2048 or 2340 bytes. The 16-byte FIFO backpressures through fifo_full; the loader never drops an in-window byte.

Optional Feature:
- Macro: CD_LOADER_SYNC_CHECK_EN.
- With the macro defined:
  - Bytes at offsets 0 and 11 are compared against 0x00; offsets 1–10 against 0xFF.
  - Any mismatch sets sync_err, which is sticky until the next start or rst.
  - Data delivery is unaffected.
- Without the macro: sync_err tied 0; no comparator logic.

Decomposition:
- Package cd_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DONE);
  - the SECTOR_BYTES, offset and length constants;
  - the sync byte values.
- Sub-module cd_sector_window (combinational): inputs byte_cnt and mode; outputs in_win and last_byte. The FSM stays in cd_sector_loader.

Test Plan:
- 2048 mode, FIFO never full, byte_valid=1 continuously:
  - exactly 2048 fifo_we pulses, first carrying sector byte 24, last carrying byte 2071;
  - fifo_clr one cycle after start;
  - sector_done one cycle after the 2352nd accept.
- 2340 mode, bytes = offset[7:0]: first write 0x0C, last write 0x2F (offset 2351); 2340 writes total.
- fifo_full held high for 5 cycles while in window:
  - byte_ready=0 and fifo_we=0 for those 5 cycles;
  - the next write carries the stalled byte, with no loss and no duplication.
- fifo_rd_active pulsed on every third in-window cycle: no fifo_we in those cycles; total write count still 2048.
- abort at byte 100, then start 3 cycles later: no sector_done for the aborted sector; the new sector clears the FIFO and delivers its full window.
- With CD_LOADER_SYNC_CHECK_EN, corrupt byte 5 to 0xFE:
  - sync_err=1 from the cycle after byte 5 is accepted until the next start;
  - 2048 writes still occur.
